dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Data-memory responder between a CPU load/store port and a single-port,
// synchronous-read SRAM. Stores are posted into a small circular store buffer
// and retired to the SRAM when the port is free. Loads go straight to the SRAM
// and have any newer buffered bytes for the same word merged into the returned
// data, so a load always observes the stores accepted before it.
//
// Parameters
//   ADDR_W    SRAM word-address width
//   SB_DEPTH  store-buffer entries (power of two, >= 2)
//
// Ports
//   clk, rst        single clock; synchronous active-high reset
//   ce              CPU chip enable; no request is accepted while low
//   re, read_addr   load request and its byte address
//   we, write_addr  store request and its byte address
//   write_instr     store data
//   write           store byte enables (bit i covers data[8i+7:8i])
//   read_instr      load data, one cycle after the load is issued
//   rvalid          read_instr carries returning load data this cycle
//   stall           store not accepted this cycle (buffer full); CPU holds
//   sb_empty        store buffer holds no entries
//   mem_en, mem_we, mem_addr, mem_wdata   SRAM request
//   mem_rdata       SRAM read data, one cycle after a read request
//
// Port arbitration, highest priority first:
//   buffer full -> retire head store
//   load issued -> SRAM read
//   buffer busy -> retire head store
//   otherwise   -> SRAM idle
// A load arriving while the buffer is full is not issued that cycle; the CPU
// keeps re asserted and the load goes out as soon as one entry has retired.
// -----------------------------------------------------------------------------
module dmem_responder #(
   parameter int ADDR_W   = 10,
   parameter int SB_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ce,
   input  logic              re,
   input  logic              we,
   input  logic [31:0]       read_addr,
   input  logic [31:0]       write_addr,
   input  logic [31:0]       write_instr,
   input  logic [3:0]        write,
   output logic [31:0]       read_instr,
   output logic              rvalid,
   output logic              stall,
   output logic              sb_empty,
   output logic              mem_en,
   output logic [3:0]        mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   localparam int PTR_W = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
      logic [3:0]        be;
   } sb_entry_t;

   // Who owns the SRAM port this cycle.
   typedef enum logic [1:0] {
      GNT_IDLE,
      GNT_LOAD,
      GNT_DRAIN
   } grant_e;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   sb_entry_t        sb_mem [SB_DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [CNT_W-1:0] count;

   logic             rvalid_q;     // a load was issued last cycle
   logic [31:0]      fwd_data_q;   // forwarded bytes captured at issue
   logic [3:0]       fwd_mask_q;   // which bytes of fwd_data_q override SRAM
   logic [31:0]      hold_q;       // last returned load data

   // ---------------------------------------------------------------------------
   // Request decode and arbitration
   // ---------------------------------------------------------------------------
   logic [ADDR_W-1:0] load_word;
   logic [ADDR_W-1:0] store_word;
   logic              store_req;
   logic              store_push;
   logic              sb_full;
   logic              load_req;
   grant_e            grant;
   logic              drain;

   // Byte offset and bits above the SRAM range carry no meaning here.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{read_addr[31:ADDR_W+2], read_addr[1:0],
                               write_addr[31:ADDR_W+2], write_addr[1:0]};

   assign load_word  = read_addr[ADDR_W+1:2];
   assign store_word = write_addr[ADDR_W+1:2];

   // NOTE: every signal driven in an always_comb gets a default at the top of
   // the block, so no path can leave it unassigned and infer a latch.
   always_comb begin
      sb_full    = (count == CNT_W'(SB_DEPTH));
      // An all-zero byte-enable store is accepted but carries nothing.
      store_req  = ce && we && (write != 4'b0000);
      store_push = store_req && !sb_full;
      // When full the port belongs to the drain, so no load can be issued;
      // this also covers a load paired with a stalled store.
      load_req   = ce && re && !sb_full;

      grant = GNT_IDLE;
      if (sb_full) begin
         grant = GNT_DRAIN;
      end else if (load_req) begin
         grant = GNT_LOAD;
      end else if (count != '0) begin
         grant = GNT_DRAIN;
      end
      drain = (grant == GNT_DRAIN);
   end

   // ---------------------------------------------------------------------------
   // SRAM request. Held at zero throughout reset.
   // ---------------------------------------------------------------------------
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 4'b0000;
      mem_addr  = '0;
      mem_wdata = '0;
      if (!rst) begin
         unique case (grant)
            GNT_LOAD: begin
               mem_en   = 1'b1;
               mem_addr = load_word;
            end
            GNT_DRAIN: begin
               mem_en    = 1'b1;
               mem_we    = sb_mem[head].be;
               mem_addr  = sb_mem[head].addr;
               mem_wdata = sb_mem[head].data;
            end
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Store-to-load forwarding snapshot.
   // Walk the live entries oldest to youngest so the youngest matching store
   // wins each byte. The head entry is still live in the cycle it retires,
   // and a store pushed this cycle is not yet in the buffer, so a load sees
   // exactly the stores accepted before it.
   // ---------------------------------------------------------------------------
   logic [31:0]      fwd_data;
   logic [3:0]       fwd_mask;
   logic [PTR_W-1:0] fwd_idx;

   always_comb begin
      fwd_data = '0;
      fwd_mask = '0;
      fwd_idx  = head;
      for (int i = 0; i < SB_DEPTH; i++) begin
         fwd_idx = head + PTR_W'(i);
         if ((CNT_W'(i) < count) && (sb_mem[fwd_idx].addr == load_word)) begin
            for (int b = 0; b < 4; b++) begin
               if (sb_mem[fwd_idx].be[b]) begin
                  fwd_data[8*b +: 8] = sb_mem[fwd_idx].data[8*b +: 8];
                  fwd_mask[b]        = 1'b1;
               end
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Buffer storage. Entries are only ever read while count says they are
   // live, so stale contents after reset are never observed.
   // ---------------------------------------------------------------------------
   // NOTE: the entry array has no reset; validity is tracked by count and the
   // pointers alone, which keeps the storage a plain register file.
   always_ff @(posedge clk) begin
      if (store_push) begin
         sb_mem[tail] <= '{addr: store_word, data: write_instr, be: write};
      end
   end

   // ---------------------------------------------------------------------------
   // Pointers, occupancy and load return path
   // ---------------------------------------------------------------------------
   logic [31:0] merged;
   logic [31:0] byte_mask;

   always_comb begin
      byte_mask = {{8{fwd_mask_q[3]}}, {8{fwd_mask_q[2]}},
                   {8{fwd_mask_q[1]}}, {8{fwd_mask_q[0]}}};
      merged    = (fwd_data_q & byte_mask) | (mem_rdata & ~byte_mask);
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         head       <= '0;
         tail       <= '0;
         count      <= '0;
         rvalid_q   <= 1'b0;
         fwd_data_q <= '0;
         fwd_mask_q <= '0;
         hold_q     <= '0;
      end else begin
         if (store_push) begin
            tail <= tail + PTR_W'(1);
         end
         if (drain) begin
            head <= head + PTR_W'(1);
         end
         // Push and drain in the same cycle leave the occupancy unchanged.
         count <= count + CNT_W'(store_push) - CNT_W'(drain);

         rvalid_q <= (grant == GNT_LOAD);
         if (grant == GNT_LOAD) begin
            fwd_data_q <= fwd_data;
            fwd_mask_q <= fwd_mask;
         end
         if (rvalid_q) begin
            hold_q <= merged;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // CPU-side outputs. The SRAM read data is valid in the return cycle, so
   // the merged word is presented then and held afterwards.
   // ---------------------------------------------------------------------------
   assign rvalid     = rvalid_q && !rst;
   assign read_instr = rst ? 32'h0 : (rvalid_q ? merged : hold_q);
   assign stall      = !rst && store_req && sb_full;
   assign sb_empty   = rst || (count == '0);

endmodule
